cci_mpf_shim_pwrite_heap_merge: RTL and testbench

// FIU-edge consumer of partial-write update traffic. Holds the write-data heap:
//   - AFU-edge full-line writes are stored here.
//   - Byte-masked updates (upd_*) from the partial-write shim are merged into stored lines.
//   - The FIU edge reads merged lines back for transmission.

---
 rtl/cci_mpf_shim_pwrite_heap_merge.sv | 154 +++++++++++++++
 tb/tb_cci_mpf_shim_pwrite_heap_merge.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_pwrite_heap_merge.sv
// Write-data heap with byte-masked merge; define MPF_PWRITE_HEAP_MERGE_FWD_CNT_EN to enable fwd_hit_cnt.
// Latency: rd accepted at T returns rd_rsp_valid at T+3; upd at T is visible to rd at T+1.
// Backpressure: upd never stalls; wr stalls behind upd; rd stalls behind upd and wr.
module cci_mpf_shim_pwrite_heap_merge #(
  parameter int N_WRITE_HEAP_ENTRIES = 64,
  parameter int N_CL_PER_ENTRY       = 4,
  parameter int CL_DATA_WIDTH        = 512,
  localparam int IW = $clog2(N_WRITE_HEAP_ENTRIES),
  localparam int CW = $clog2(N_CL_PER_ENTRY),
  localparam int BW = CL_DATA_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     upd_en,
  input  logic [IW-1:0]            upd_idx,
  input  logic [CW-1:0]            upd_clNum,
  input  logic [CL_DATA_WIDTH-1:0] upd_data,
  input  logic [BW-1:0]            upd_mask,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_idx,
  input  logic [CW-1:0]            wr_clNum,
  input  logic [CL_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [IW-1:0]            rd_idx,
  input  logic [CW-1:0]            rd_clNum,
  output logic                     rd_ready,
  output logic                     rd_rsp_valid,
  output logic [CL_DATA_WIDTH-1:0] rd_rsp_data,
  output logic [31:0]              fwd_hit_cnt
);

  localparam int AW    = IW + CW;
  localparam int DEPTH = N_WRITE_HEAP_ENTRIES * N_CL_PER_ENTRY;

  typedef enum logic [1:0] {
    OP_UPD = 2'd0,
    OP_WR  = 2'd1,
    OP_RD  = 2'd2
  } op_e;

  typedef struct packed {
    op_e                     op;
    logic [AW-1:0]           addr;
    logic [CL_DATA_WIDTH-1:0] data;
    logic [BW-1:0]           mask;
  } req_t;

  logic [CL_DATA_WIDTH-1:0] heap_ram [DEPTH];

  logic                     s0_vld;
  req_t                     s0_req;
  logic                     s1_vld, s2_vld, s3_vld, s4_vld;
  req_t                     s1_req, s2_req;
  logic [CL_DATA_WIDTH-1:0] ram_q, s2_ram;
  logic [AW-1:0]            s3_addr, s4_addr;
  logic [CL_DATA_WIDTH-1:0] s3_line, s4_line;
  logic                     hit3, hit4, s2_we;
  logic [CL_DATA_WIDTH-1:0] s2_base, s2_line;

  assign wr_ready = ~upd_en;
  assign rd_ready = ~upd_en & ~wr_en;

  // Fixed priority upd > wr > rd; the losers simply see ready low and retry.
  always_comb begin
    s0_vld = 1'b0;
    s0_req = '0;
    if (upd_en) begin
      s0_vld      = 1'b1;
      s0_req.op   = OP_UPD;
      s0_req.addr = {upd_idx, upd_clNum};
      s0_req.data = upd_data;
      s0_req.mask = upd_mask;
    end else if (wr_en) begin
      s0_vld      = 1'b1;
      s0_req.op   = OP_WR;
      s0_req.addr = {wr_idx, wr_clNum};
      s0_req.data = wr_data;
      s0_req.mask = '1;
    end else if (rd_en) begin
      s0_vld      = 1'b1;
      s0_req.op   = OP_RD;
      s0_req.addr = {rd_idx, rd_clNum};
    end
  end

  // S3 holds the result committed last cycle (not yet readable from RAM);
  // S4 holds the one written on the same edge as this op's RAM read (old data returned).
  assign hit3    = s3_vld && (s3_addr == s2_req.addr);
  assign hit4    = s4_vld && (s4_addr == s2_req.addr);
  assign s2_base = hit3 ? s3_line : (hit4 ? s4_line : s2_ram);
  assign s2_we   = s2_vld && (s2_req.op != OP_RD);

  always_comb begin
    s2_line = s2_base;
    case (s2_req.op)
      OP_UPD: begin
        for (int b = 0; b < BW; b++) begin
          if (s2_req.mask[b]) s2_line[b*8 +: 8] = s2_req.data[b*8 +: 8];
        end
      end
      OP_WR:   s2_line = s2_req.data;
      default: s2_line = s2_base;
    endcase
  end

  // Payload path and RAM are not reset; write enable comes from reset-cleared valids.
  always_ff @(posedge clk) begin
    if (s0_vld) ram_q <= heap_ram[s0_req.addr];
    s1_req  <= s0_req;
    s2_req  <= s1_req;
    s2_ram  <= ram_q;
    if (s2_we) heap_ram[s2_req.addr] <= s2_line;
    s3_addr <= s2_req.addr;
    s3_line <= s2_line;
    s4_addr <= s3_addr;
    s4_line <= s3_line;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      s3_vld       <= 1'b0;
      s4_vld       <= 1'b0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_data  <= '0;
    end else begin
      s1_vld       <= s0_vld;
      s2_vld       <= s1_vld;
      s3_vld       <= s2_we;
      s4_vld       <= s3_vld;
      rd_rsp_valid <= s2_vld && (s2_req.op == OP_RD);
      if (s2_vld && (s2_req.op == OP_RD)) rd_rsp_data <= s2_line;
    end
  end

`ifdef MPF_PWRITE_HEAP_MERGE_FWD_CNT_EN
  logic [31:0] fwd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_cnt <= '0;
    end else if (s2_vld && (hit3 || hit4) && (fwd_cnt != 32'hFFFF_FFFF)) begin
      fwd_cnt <= fwd_cnt + 32'd1;
    end
  end

  assign fwd_hit_cnt = fwd_cnt;
`else
  assign fwd_hit_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_pwrite_heap_merge.sv
// Directed bench for the write-data heap merge pipeline; expectations are hand-computed.
module tb_cci_mpf_shim_pwrite_heap_merge;

`ifdef MPF_PWRITE_HEAP_MERGE_FWD_CNT_EN
  localparam int FWD_SCALE = 1;
`else
  localparam int FWD_SCALE = 0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         upd_en;
  logic [5:0]   upd_idx;
  logic [1:0]   upd_clNum;
  logic [511:0] upd_data;
  logic [63:0]  upd_mask;
  logic         wr_en;
  logic [5:0]   wr_idx;
  logic [1:0]   wr_clNum;
  logic [511:0] wr_data;
  logic         wr_ready;
  logic         rd_en;
  logic [5:0]   rd_idx;
  logic [1:0]   rd_clNum;
  logic         rd_ready;
  logic         rd_rsp_valid;
  logic [511:0] rd_rsp_data;
  logic [31:0]  fwd_hit_cnt;

  int total = 0;
  int bad   = 0;

  cci_mpf_shim_pwrite_heap_merge dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .upd_en       (upd_en),
    .upd_idx      (upd_idx),
    .upd_clNum    (upd_clNum),
    .upd_data     (upd_data),
    .upd_mask     (upd_mask),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_clNum     (wr_clNum),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_en        (rd_en),
    .rd_idx       (rd_idx),
    .rd_clNum     (rd_clNum),
    .rd_ready     (rd_ready),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .fwd_hit_cnt  (fwd_hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_wr(input logic [7:0] a, input logic [511:0] d);
    wr_en = 1'b1;
    {wr_idx, wr_clNum} = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic op_upd(input logic [7:0] a, input logic [511:0] d, input logic [63:0] m);
    upd_en = 1'b1;
    {upd_idx, upd_clNum} = a;
    upd_data = d;
    upd_mask = m;
    step();
    upd_en = 1'b0;
  endtask

  // Called right after the cycle in which the read was accepted.
  task automatic rsp_check(input logic [511:0] exp, input string tag);
    step();
    chk({tag, "_vld_t1"}, rd_rsp_valid, 1'b0);
    step();
    chk({tag, "_vld_t3"}, rd_rsp_valid, 1'b1);
    chk({tag, "_data"}, rd_rsp_data, exp);
    step();
    chk({tag, "_vld_t4"}, rd_rsp_valid, 1'b0);
  endtask

  task automatic rd_check(input logic [7:0] a, input logic [511:0] exp, input string tag);
    rd_en = 1'b1;
    {rd_idx, rd_clNum} = a;
    step();
    rd_en = 1'b0;
    rsp_check(exp, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    upd_en = 1'b0; upd_idx = '0; upd_clNum = '0; upd_data = '0; upd_mask = '0;
    wr_en = 1'b0; wr_idx = '0; wr_clNum = '0; wr_data = '0;
    rd_en = 1'b0; rd_idx = '0; rd_clNum = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_vld", rd_rsp_valid, 1'b0);
    chk("rst_rsp_data", rd_rsp_data, '0);
    chk("rst_fwd_cnt", fwd_hit_cnt, '0);
    reset_n = 1'b1;
    step();

    // 1: store then read from RAM after two idle cycles
    op_wr(8'd5, fill(8'hAA));
    step();
    step();
    rd_check(8'd5, fill(8'hAA), "t1");

    // 2: store, merge byte0, read -- each forwarded from S3
    op_wr(8'd5, fill(8'hAA));
    op_upd(8'd5, fill(8'h11), 64'h1);
    rd_check(8'd5, (fill(8'hAA) & ~512'hFF) | 512'h11, "t2");
    chk("t2_fwd_cnt", fwd_hit_cnt, 2 * FWD_SCALE);

    // 3: three back-to-back merges onto zeros
    op_wr(8'd7, '0);
    op_upd(8'd7, fill(8'h11), 64'h1);
    op_upd(8'd7, fill(8'h22), 64'h2);
    op_upd(8'd7, fill(8'h33), 64'h1);
    rd_check(8'd7, 512'h2233, "t3_fwd");
    rd_check(8'd7, 512'h2233, "t3_ram");
    chk("t3_fwd_cnt", fwd_hit_cnt, 6 * FWD_SCALE);

    // 4: wr held off by upd for two cycles, then lands after the upds
    upd_en = 1'b1; {upd_idx, upd_clNum} = 8'd12; upd_data = fill(8'hCC); upd_mask = '1;
    wr_en = 1'b1; {wr_idx, wr_clNum} = 8'd12; wr_data = fill(8'h5A);
    #1;
    chk("t4_wr_rdy_c0", wr_ready, 1'b0);
    chk("t4_rd_rdy_c0", rd_ready, 1'b0);
    step();
    chk("t4_wr_rdy_c1", wr_ready, 1'b0);
    step();
    upd_en = 1'b0;
    #1;
    chk("t4_wr_rdy_c2", wr_ready, 1'b1);
    chk("t4_rd_rdy_c2", rd_ready, 1'b0);
    step();
    wr_en = 1'b0;
    rd_check(8'd12, fill(8'h5A), "t4");

    // 5: rd stalled four cycles behind upd traffic to another line
    op_wr(8'd3, fill(8'h33));
    upd_en = 1'b1; {upd_idx, upd_clNum} = 8'd9; upd_data = fill(8'h99); upd_mask = '1;
    rd_en = 1'b1; {rd_idx, rd_clNum} = 8'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_rd_rdy_stall%0d", i), rd_ready, 1'b0);
      chk($sformatf("t5_rsp_vld_stall%0d", i), rd_rsp_valid, 1'b0);
      step();
    end
    upd_en = 1'b0;
    #1;
    chk("t5_rd_rdy_go", rd_ready, 1'b1);
    step();
    rd_en = 1'b0;
    rsp_check(fill(8'h33), "t5");

    // 6: reset while an upd is in S1 and a read response is on the output
    op_wr(8'd2, fill(8'h77));
    step();
    step();
    rd_en = 1'b1; {rd_idx, rd_clNum} = 8'd2;
    step();
    rd_en = 1'b0;
    step();
    op_upd(8'd2, fill(8'hEE), '1);
    chk("t6_pre_vld", rd_rsp_valid, 1'b1);
    chk("t6_pre_data", rd_rsp_data, fill(8'h77));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_vld", rd_rsp_valid, 1'b0);
    chk("t6_rst_data", rd_rsp_data, '0);
    step();
    step();
    chk("t6_rst_fwd_cnt", fwd_hit_cnt, '0);
    reset_n = 1'b1;
    step();
    chk("t6_post_vld", rd_rsp_valid, 1'b0);
    rd_check(8'd2, fill(8'h77), "t6_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
